// File: rtl/execute_cycle_pkg.sv
// Shared definitions for the RV32I execute stage.
// Holds the default datapath width, the ALU control and forward-select
// encodings, and the state type of the multi-cycle multiply sequencer.
package execute_cycle_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  // ALU control encodings (ALUControlE)
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_MUL = 3'b110;

  // Forward-select encodings (ForwardA_E / ForwardB_E); 2'b11 falls back to the register file
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_BUSY = 1'b1
  } mulState_t;

endpackage

// File: rtl/execute_cycle_if.sv
// Bundle of the decode->execute inputs, hazard-unit forwarding selects,
// fetch redirect and EX/MEM register outputs of the execute stage.
//   master : upstream side (ID/EX register, hazard unit, fetch, memory stage)
//   slave  : the execute stage itself
interface execute_cycle_if import execute_cycle_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  // ID/EX control
  logic                  RegWriteE;
  logic                  MemWriteE;
  logic [1:0]            ResultSrcE;
  logic                  BranchE;
  logic                  JumpE;
  logic [2:0]            ALUControlE;
  logic                  ALUSrcE;
  // ID/EX data
  logic [DATA_WIDTH-1:0] RD1_E;
  logic [DATA_WIDTH-1:0] RD2_E;
  logic [DATA_WIDTH-1:0] Imm_Ext_E;
  logic [4:0]            RD_E;
  logic [DATA_WIDTH-1:0] PCE;
  logic [DATA_WIDTH-1:0] PCPlus4E;
  // forwarding
  logic [1:0]            ForwardA_E;
  logic [1:0]            ForwardB_E;
  logic [DATA_WIDTH-1:0] ResultW;
  // branch resolution and stall
  logic                  PCSrcE;
  logic [DATA_WIDTH-1:0] PCTargetE;
  logic                  StallE;
  // EX/MEM register
  logic                  RegWriteM;
  logic                  MemWriteM;
  logic [1:0]            ResultSrcM;
  logic [4:0]            RD_M;
  logic [DATA_WIDTH-1:0] PCPlus4M;
  logic [DATA_WIDTH-1:0] WriteDataM;
  logic [DATA_WIDTH-1:0] ALU_ResultM;

  modport master (
    output RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUControlE, ALUSrcE,
    output RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E,
    output ForwardA_E, ForwardB_E, ResultW,
    input  PCSrcE, PCTargetE, StallE,
    input  RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM
  );

  modport slave (
    input  RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUControlE, ALUSrcE,
    input  RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E,
    input  ForwardA_E, ForwardB_E, ResultW,
    output PCSrcE, PCTargetE, StallE,
    output RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM
  );

endinterface

// File: rtl/execute_cycle_alu.sv
// Combinational single-cycle ALU of the execute stage (multiply is not handled here).
// Ports:
//   srcA, srcB  in  DATA_WIDTH  operands
//   aluControl  in  3           operation select (package ALU_* encodings)
//   result      out DATA_WIDTH  add/sub wrap; slt is signed and yields 0/1; unknown codes -> 0
//   zero        out 1           result == 0
module execute_cycle_alu import execute_cycle_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] srcA,
  input  logic [DATA_WIDTH-1:0] srcB,
  input  logic [2:0]            aluControl,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero
);

  always_comb begin
    result = '0;
    case (aluControl)
      ALU_ADD: result = srcA + srcB;
      ALU_SUB: result = srcA - srcB;
      ALU_AND: result = srcA & srcB;
      ALU_OR:  result = srcA | srcB;
      ALU_SLT: result = {{(DATA_WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/execute_cycle.sv
// EX stage of the 5-stage RV32I pipeline.
// Selects forwarded operands, runs the ALU, resolves branch/jump and the
// branch target, and registers all EX->MEM control and data.
// Optional build macro EXEC_MUL_EN adds a multi-cycle multiply that stalls
// the upstream stages while it is busy; without it StallE is tied low and
// ALU code 110 yields 0.
// Ports:
//   clk  in  rising-edge clock
//   rst  in  asynchronous reset, active-high (clears EX/MEM register and multiply FSM)
//   ex   execute_cycle_if.slave: E-stage inputs, forwarding selects, PCSrcE/PCTargetE
//        (combinational), StallE, and the registered *M outputs
module execute_cycle import execute_cycle_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MUL_CYCLES = 4
) (
  input logic           clk,
  input logic           rst,
  execute_cycle_if.slave ex
);

  if (MUL_CYCLES < 2) begin : gBadMulCycles
    $error("MUL_CYCLES must be at least 2");
  end

  logic [DATA_WIDTH-1:0] srcA;
  logic [DATA_WIDTH-1:0] srcB;
  logic [DATA_WIDTH-1:0] writeData;
  logic [DATA_WIDTH-1:0] aluResult;
  logic [DATA_WIDTH-1:0] resultE;
  logic                  zeroE;
  logic                  stall;
  logic                  bubble;

  always_comb begin
    case (ex.ForwardA_E)
      FWD_WB:  srcA = ex.ResultW;
      FWD_MEM: srcA = ex.ALU_ResultM;
      default: srcA = ex.RD1_E;
    endcase
    case (ex.ForwardB_E)
      FWD_WB:  writeData = ex.ResultW;
      FWD_MEM: writeData = ex.ALU_ResultM;
      default: writeData = ex.RD2_E;
    endcase
  end

  assign srcB = ex.ALUSrcE ? ex.Imm_Ext_E : writeData;

  execute_cycle_alu #(.DATA_WIDTH(DATA_WIDTH)) alu (
    .srcA       (srcA),
    .srcB       (srcB),
    .aluControl (ex.ALUControlE),
    .result     (aluResult),
    .zero       (zeroE)
  );

`ifdef EXEC_MUL_EN
  localparam int CNT_W = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;

  mulState_t             state;
  mulState_t             stateNext;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cntNext;
  logic [DATA_WIDTH-1:0] mulA;
  logic [DATA_WIDTH-1:0] mulB;
  logic [DATA_WIDTH-1:0] mulLow;
  logic                  mulLoad;
  logic                  mulDone;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MUL_IDLE;
      cnt   <= '0;
      mulA  <= '0;
      mulB  <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      // operands are captured at issue so forwarding changes during the stall cannot disturb them
      if (mulLoad) begin
        mulA <= srcA;
        mulB <= srcB;
      end
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    stall     = 1'b0;
    bubble    = 1'b0;
    mulLoad   = 1'b0;
    mulDone   = 1'b0;
    case (state)
      MUL_IDLE: begin
        if (ex.ALUControlE == ALU_MUL) begin
          stall     = 1'b1;
          bubble    = 1'b1;
          mulLoad   = 1'b1;
          cntNext   = CNT_W'(MUL_CYCLES - 2);
          stateNext = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        if (cnt != '0) begin
          stall   = 1'b1;
          bubble  = 1'b1;
          cntNext = cnt - CNT_W'(1);
        end else begin
          mulDone   = 1'b1;
          stateNext = MUL_IDLE;
        end
      end
      default: stateNext = MUL_IDLE;
    endcase
  end

  // low half of a WxW product is the same for signed and unsigned operands
  assign mulLow  = mulA * mulB;
  assign resultE = mulDone ? mulLow : aluResult;
`else
  assign stall   = 1'b0;
  assign bubble  = 1'b0;
  assign resultE = aluResult;
`endif

  assign ex.StallE    = stall;
  assign ex.PCSrcE    = ~stall & ((ex.BranchE & zeroE) | ex.JumpE);
  assign ex.PCTargetE = ex.PCE + ex.Imm_Ext_E;

  // a bubble kills the write enables and leaves the remaining fields as they were
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex.RegWriteM   <= 1'b0;
      ex.MemWriteM   <= 1'b0;
      ex.ResultSrcM  <= '0;
      ex.RD_M        <= '0;
      ex.PCPlus4M    <= '0;
      ex.WriteDataM  <= '0;
      ex.ALU_ResultM <= '0;
    end else begin
      ex.RegWriteM <= bubble ? 1'b0 : ex.RegWriteE;
      ex.MemWriteM <= bubble ? 1'b0 : ex.MemWriteE;
      if (!bubble) begin
        ex.ResultSrcM  <= ex.ResultSrcE;
        ex.RD_M        <= ex.RD_E;
        ex.PCPlus4M    <= ex.PCPlus4E;
        ex.WriteDataM  <= writeData;
        ex.ALU_ResultM <= resultE;
      end
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
module tb_execute_cycle;
  import execute_cycle_pkg::*;

  logic clk;
  logic rst;
  int   testsRun;
  int   failCount;

  execute_cycle_if #(.DATA_WIDTH(32)) bus ();

  execute_cycle #(.DATA_WIDTH(32), .MUL_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .ex  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    bus.RegWriteE   = 1'b0;
    bus.MemWriteE   = 1'b0;
    bus.ResultSrcE  = 2'b00;
    bus.BranchE     = 1'b0;
    bus.JumpE       = 1'b0;
    bus.ALUControlE = ALU_ADD;
    bus.ALUSrcE     = 1'b0;
    bus.RD1_E       = '0;
    bus.RD2_E       = '0;
    bus.Imm_Ext_E   = '0;
    bus.RD_E        = '0;
    bus.PCE         = '0;
    bus.PCPlus4E    = '0;
    bus.ForwardA_E  = FWD_RF;
    bus.ForwardB_E  = FWD_RF;
    bus.ResultW     = '0;
  endtask

  task automatic aluOp(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    clearInputs();
    bus.RegWriteE   = 1'b1;
    bus.RD_E        = 5'd3;
    bus.ALUControlE = ctrl;
    bus.RD1_E       = a;
    bus.RD2_E       = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    testsRun  = 0;
    failCount = 0;
    rst = 1'b1;
    clearInputs();
    #12 rst = 1'b0;

    // load every E input with nonzero values, then reset between edges
    @(negedge clk);
    bus.RegWriteE   = 1'b1;
    bus.MemWriteE   = 1'b1;
    bus.ResultSrcE  = 2'b10;
    bus.RD_E        = 5'd7;
    bus.PCE         = 32'h100;
    bus.PCPlus4E    = 32'h104;
    bus.RD1_E       = 32'd5;
    bus.RD2_E       = 32'h33;
    bus.Imm_Ext_E   = 32'hFFFF_FFFD;
    bus.ALUSrcE     = 1'b1;
    bus.ALUControlE = ALU_ADD;
    bus.ResultW     = 32'h77;
    step();
    checkVal("add_imm_result", bus.ALU_ResultM, 32'd2);
    checkVal("add_writedata", bus.WriteDataM, 32'h33);
    checkVal("add_rd", {27'd0, bus.RD_M}, 32'd7);
    checkVal("add_pcplus4", bus.PCPlus4M, 32'h104);
    checkVal("add_ctrl", {28'd0, bus.ResultSrcM, bus.RegWriteM, bus.MemWriteM}, 32'hB);
    #2 rst = 1'b1;
    #1;
    checkVal("rst_ctrl", {28'd0, bus.ResultSrcM, bus.RegWriteM, bus.MemWriteM}, 32'h0);
    checkVal("rst_rd", {27'd0, bus.RD_M}, 32'd0);
    checkVal("rst_pcplus4", bus.PCPlus4M, 32'd0);
    checkVal("rst_writedata", bus.WriteDataM, 32'd0);
    checkVal("rst_result", bus.ALU_ResultM, 32'd0);
    #1 rst = 1'b0;

    // ALU operations
    aluOp(ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    step();
    checkVal("slt_neg_vs_1", bus.ALU_ResultM, 32'd1);
    aluOp(ALU_SLT, 32'd1, 32'hFFFF_FFFF);
    step();
    checkVal("slt_1_vs_neg", bus.ALU_ResultM, 32'd0);
    aluOp(ALU_AND, 32'h0000_F0F0, 32'h0000_FF00);
    step();
    checkVal("and", bus.ALU_ResultM, 32'h0000_F000);
    aluOp(ALU_OR, 32'h0000_F0F0, 32'h0000_FF00);
    step();
    checkVal("or", bus.ALU_ResultM, 32'h0000_FFF0);
    aluOp(ALU_ADD, 32'hFFFF_FFFF, 32'd1);
    step();
    checkVal("add_wrap", bus.ALU_ResultM, 32'd0);
    aluOp(3'b100, 32'd5, 32'd3);
    step();
    checkVal("undef_code", bus.ALU_ResultM, 32'd0);

    // forwarding: first leave 0x10 in ALU_ResultM
    aluOp(ALU_ADD, 32'h10, 32'd0);
    step();
    checkVal("fwd_setup", bus.ALU_ResultM, 32'h10);
    aluOp(ALU_SUB, 32'h1111, 32'h2222);
    bus.ForwardA_E = FWD_MEM;
    bus.ForwardB_E = FWD_WB;
    bus.ResultW    = 32'h20;
    step();
    checkVal("fwd_sub_result", bus.ALU_ResultM, 32'hFFFF_FFF0);
    checkVal("fwd_writedata", bus.WriteDataM, 32'h20);
    aluOp(ALU_SUB, 32'd9, 32'd4);
    bus.ForwardA_E = 2'b11;
    bus.ForwardB_E = 2'b11;
    bus.ResultW    = 32'h99;
    step();
    checkVal("fwd11_result", bus.ALU_ResultM, 32'd5);
    checkVal("fwd11_writedata", bus.WriteDataM, 32'd4);

    // branch / jump resolution (combinational)
    aluOp(ALU_SUB, 32'h55, 32'h55);
    bus.BranchE   = 1'b1;
    bus.PCE       = 32'h100;
    bus.Imm_Ext_E = 32'h40;
    #1;
    checkVal("beq_taken", {31'd0, bus.PCSrcE}, 32'd1);
    checkVal("beq_target", bus.PCTargetE, 32'h140);
    checkVal("no_stall", {31'd0, bus.StallE}, 32'd0);
    bus.RD2_E = 32'h56;
    #1;
    checkVal("beq_not_taken", {31'd0, bus.PCSrcE}, 32'd0);
    bus.JumpE = 1'b1;
    #1;
    checkVal("jump_taken", {31'd0, bus.PCSrcE}, 32'd1);
    bus.PCE       = 32'hFFFF_FFF0;
    bus.Imm_Ext_E = 32'h20;
    #1;
    checkVal("target_wrap", bus.PCTargetE, 32'h10);

    // leave a known RD_M / result before the multiply section
    aluOp(ALU_ADD, 32'd1, 32'd2);
    bus.RD_E = 5'd4;
    step();
    checkVal("pre_mul_result", bus.ALU_ResultM, 32'd3);

`ifdef EXEC_MUL_EN
    // mul 7 x 0xFFFFFFFE, SrcA taken from ResultW through forwarding
    aluOp(ALU_MUL, 32'hDEAD, 32'hFFFF_FFFE);
    bus.RD_E       = 5'd9;
    bus.ForwardA_E = FWD_WB;
    bus.ResultW    = 32'd7;
    #1;
    checkVal("mul_stall_c0", {31'd0, bus.StallE}, 32'd1);
    step();
    checkVal("mul_stall_c1", {31'd0, bus.StallE}, 32'd1);
    checkVal("mul_bubble_c1", {31'd0, bus.RegWriteM}, 32'd0);
    checkVal("mul_hold_rd", {27'd0, bus.RD_M}, 32'd4);
    checkVal("mul_hold_result", bus.ALU_ResultM, 32'd3);
    bus.ResultW = 32'h1234;
    step();
    checkVal("mul_stall_c2", {31'd0, bus.StallE}, 32'd1);
    checkVal("mul_bubble_c2", {31'd0, bus.RegWriteM}, 32'd0);
    step();
    checkVal("mul_stall_released", {31'd0, bus.StallE}, 32'd0);
    checkVal("mul_bubble_c3", {31'd0, bus.RegWriteM}, 32'd0);
    step();
    checkVal("mul_result", bus.ALU_ResultM, 32'hFFFF_FFF2);
    checkVal("mul_regwrite", {31'd0, bus.RegWriteM}, 32'd1);
    checkVal("mul_rd", {27'd0, bus.RD_M}, 32'd9);

    // reset while BUSY
    aluOp(ALU_MUL, 32'd3, 32'd3);
    step();
    checkVal("mul2_busy", {31'd0, bus.StallE}, 32'd1);
    #2;
    rst = 1'b1;
    bus.ALUControlE = ALU_ADD;
    bus.RD1_E       = 32'd20;
    bus.RD2_E       = 32'd22;
    #1;
    checkVal("rst_busy_stall", {31'd0, bus.StallE}, 32'd0);
    checkVal("rst_busy_result", bus.ALU_ResultM, 32'd0);
    #1 rst = 1'b0;
    step();
    checkVal("post_rst_add", bus.ALU_ResultM, 32'd42);
    checkVal("post_rst_regwrite", {31'd0, bus.RegWriteM}, 32'd1);
`else
    // without the multiplier, code 110 is an ordinary zero-result op with no stall
    aluOp(ALU_MUL, 32'd7, 32'hFFFF_FFFE);
    #1;
    checkVal("mul_off_stall", {31'd0, bus.StallE}, 32'd0);
    step();
    checkVal("mul_off_result", bus.ALU_ResultM, 32'd0);
    checkVal("mul_off_regwrite", {31'd0, bus.RegWriteM}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
